sdram_mux: RTL

Three-port request arbiter upstream of the SDRAM controller. It serializes the ROM loader (16-bit writes), the sprite fetcher (64-bit, 4-word bursts) and the 68k program path (16-bit reads) onto the controller's edge-triggered rd/we interface. It captures the controller's 64-bit burst result and keeps a one-block CPU read cache, so sequential 68k fetches avoid an SDRAM round trip.

---
 rtl/sdram_mux.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdram_mux.sv
// sdram_mux: serializes loader writes, sprite bursts and CPU reads onto the SDRAM controller, with a one-line CPU read cache
// Ports: clk/init (async active-high reset); dl_* loader write port; spr_* sprite 64-bit burst port;
//        cpu_* CPU 16-bit read port; sd_* controller request/response interface.
module sdram_mux (
  input  logic        clk,
  input  logic        init,
  input  logic        dl_wr,
  input  logic [23:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic        dl_busy,
  input  logic        spr_req,
  input  logic [21:0] spr_addr,
  output logic [63:0] spr_dout,
  output logic        spr_valid,
  output logic        spr_busy,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  output logic [15:0] cpu_dout,
  output logic        cpu_valid,
  output logic        cpu_busy,
  output logic        sd_rd,
  output logic        sd_we,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wtbt,
  input  logic [63:0] sd_dout,
  input  logic        sd_ready_first,
  input  logic        sd_ready_fourth
);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE1, SETTLE2, WAIT} state_t;
  localparam logic [1:0] G_DL = 2'd0, G_SPR = 2'd1, G_CPU = 2'd2;
  state_t state, state_nxt;
  logic [1:0] gnt, gnt_nxt;
  logic [23:0] dl_a, cpu_a;
  logic [15:0] dl_d;
  logic [21:0] spr_a, tag;
  logic [63:0] line;
  logic line_ok, stale, grant, done, hit;

  function automatic logic [15:0] word_sel(input logic [63:0] l, input logic [1:0] i);
    return l[{~i, 4'd0} +: 16];
  endfunction

  assign hit = line_ok && tag == cpu_addr[23:2];
  assign grant = state == IDLE && (dl_busy || spr_busy || cpu_busy);
  assign gnt_nxt = dl_busy ? G_DL : spr_busy ? G_SPR : G_CPU;
  assign done = state == WAIT && (gnt == G_DL ? sd_ready_first : sd_ready_fourth);

  always_ff @(posedge clk or posedge init)
    if (init) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? ISSUE : IDLE;
      ISSUE:   state_nxt = SETTLE1;
      SETTLE1: state_nxt = SETTLE2;
      SETTLE2: state_nxt = WAIT;
      WAIT:    state_nxt = done ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init)
    if (init) begin
      dl_busy   <= 1'b0;
      spr_busy  <= 1'b0;
      cpu_busy  <= 1'b0;
      spr_valid <= 1'b0;
      cpu_valid <= 1'b0;
      sd_rd     <= 1'b0;
      sd_we     <= 1'b0;
      sd_addr   <= '0;
      sd_din    <= '0;
      sd_wtbt   <= '0;
      spr_dout  <= '0;
      cpu_dout  <= '0;
      gnt       <= G_DL;
      dl_a      <= '0;
      dl_d      <= '0;
      spr_a     <= '0;
      cpu_a     <= '0;
      tag       <= '0;
      line      <= '0;
      line_ok   <= 1'b0;
      stale     <= 1'b0;
    end else begin
      sd_rd     <= 1'b0;
      sd_we     <= 1'b0;
      spr_valid <= 1'b0;
      cpu_valid <= 1'b0;
      if (grant) begin
        gnt     <= gnt_nxt;
        sd_we   <= gnt_nxt == G_DL;
        sd_rd   <= gnt_nxt != G_DL;
        sd_addr <= gnt_nxt == G_DL ? {dl_a, 1'b0} : gnt_nxt == G_SPR ? {spr_a, 3'd0} : {cpu_a[23:2], 3'd0};
        sd_wtbt <= gnt_nxt == G_DL ? 2'b11 : 2'b00;
        if (gnt_nxt == G_DL) sd_din <= dl_d;
        if (gnt_nxt == G_CPU) stale <= 1'b0;
      end
      if (done && gnt == G_DL) dl_busy <= 1'b0;
      if (done && gnt == G_SPR) begin
        spr_busy  <= 1'b0;
        spr_dout  <= sd_dout;
        spr_valid <= 1'b1;
      end
      // a loader write accepted after the fill was issued may land after the read, so such a fill is not cached
      if (done && gnt == G_CPU) begin
        cpu_busy  <= 1'b0;
        line      <= sd_dout;
        tag       <= cpu_a[23:2];
        line_ok   <= !stale;
        cpu_dout  <= word_sel(sd_dout, cpu_a[1:0]);
        cpu_valid <= 1'b1;
      end
      if (spr_req && !spr_busy) begin
        spr_busy <= 1'b1;
        spr_a    <= spr_addr;
      end
      if (cpu_req && !cpu_busy) begin
        if (hit) begin
          cpu_dout  <= word_sel(line, cpu_addr[1:0]);
          cpu_valid <= 1'b1;
        end else begin
          cpu_busy <= 1'b1;
          cpu_a    <= cpu_addr;
        end
      end
      // placed last so invalidation overrides a fill completing in the same cycle
      if (dl_wr && !dl_busy) begin
        dl_busy <= 1'b1;
        dl_a    <= dl_addr;
        dl_d    <= dl_data;
        line_ok <= 1'b0;
        stale   <= 1'b1;
      end
    end
endmodule
